// File: rtl/id_stage_if.sv
// Bundle between the decode stage and its neighbours: fetch, register file,
// bypass sources and the ID/EX pipeline word consumed by execute.
interface id_stage_if #(
  parameter int DW = 16,
  parameter int AW = 3
);
  logic          if_valid;
  logic [15:0]   if_instr;
  logic [DW-1:0] if_pc;
  logic          if_stall;
  logic          flush;

  logic [AW-1:0] rf_raddr1;
  logic [AW-1:0] rf_raddr2;
  logic [DW-1:0] rf_rdata1;
  logic [DW-1:0] rf_rdata2;

  logic          mem_fwd_valid;
  logic [AW-1:0] mem_fwd_addr;
  logic [DW-1:0] mem_fwd_data;

  logic          wb_wea;
  logic [AW-1:0] wb_waddr;
  logic [DW-1:0] wb_wdata;

  logic          ex_valid;
  logic [3:0]    ex_op;
  logic [AW-1:0] ex_rd;
  logic [DW-1:0] ex_a;
  logic [DW-1:0] ex_b;
  logic [DW-1:0] ex_imm;
  logic [DW-1:0] ex_pc;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic          ex_branch;

  logic          halted;

  modport slave (
    input  if_valid, if_instr, if_pc, flush,
    input  rf_rdata1, rf_rdata2,
    input  mem_fwd_valid, mem_fwd_addr, mem_fwd_data,
    input  wb_wea, wb_waddr, wb_wdata,
    output if_stall, rf_raddr1, rf_raddr2,
    output ex_valid, ex_op, ex_rd, ex_a, ex_b, ex_imm, ex_pc,
    output ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
    output halted
  );

  modport master (
    output if_valid, if_instr, if_pc, flush,
    output rf_rdata1, rf_rdata2,
    output mem_fwd_valid, mem_fwd_addr, mem_fwd_data,
    output wb_wea, wb_waddr, wb_wdata,
    input  if_stall, rf_raddr1, rf_raddr2,
    input  ex_valid, ex_op, ex_rd, ex_a, ex_b, ex_imm, ex_pc,
    input  ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
    input  halted
  );
endinterface

// File: rtl/id_stage.sv
// Omicron decode stage: field decode, two-level operand bypass, load-use
// bubble insertion, HALT sequencing and the registered ID/EX word.
module id_stage #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input logic       clk_n,
  input logic       rst,
  id_stage_if.slave bus
);
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_J    = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT_PEND = 2'd1,
    ST_HALTED    = 2'd2
  } state_t;

  typedef struct packed {
    logic          valid;
    logic [3:0]    op;
    logic [AW-1:0] rd;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          branch;
  } id_ex_t;

  state_t state_q, state_d;
  id_ex_t ex_q, ex_d;

  logic [3:0]    op_f;
  logic [AW-1:0] rd_f, rs_f, rt_f;
  logic [DW-1:0] imm6_sx, imm12_sx;

  assign op_f     = bus.if_instr[15:12];
  assign rd_f     = bus.if_instr[9 +: AW];
  assign rs_f     = bus.if_instr[6 +: AW];
  assign rt_f     = bus.if_instr[3 +: AW];
  assign imm6_sx  = {{(DW-6){bus.if_instr[5]}}, bus.if_instr[5:0]};
  assign imm12_sx = {{(DW-12){bus.if_instr[11]}}, bus.if_instr[11:0]};

  logic [AW-1:0] raddr1, raddr2;
  logic          use1, use2;
  logic [DW-1:0] imm_c;
  logic          reg_write_c, mem_read_c, mem_write_c, branch_c;

  // SW and BEQ swap the first read port onto rd; the use flags say which
  // ports actually feed the instruction, for both operand muxing and hazards.
  always_comb begin
    raddr1      = rs_f;
    raddr2      = '0;
    use1        = 1'b0;
    use2        = 1'b0;
    imm_c       = '0;
    reg_write_c = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    branch_c    = 1'b0;
    case (op_f)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        raddr2      = rt_f;
        use1        = 1'b1;
        use2        = 1'b1;
        reg_write_c = 1'b1;
      end
      OP_ADDI: begin
        use1        = 1'b1;
        imm_c       = imm6_sx;
        reg_write_c = 1'b1;
      end
      OP_LW: begin
        use1        = 1'b1;
        imm_c       = imm6_sx;
        reg_write_c = 1'b1;
        mem_read_c  = 1'b1;
      end
      OP_SW: begin
        raddr1      = rd_f;
        raddr2      = rs_f;
        use1        = 1'b1;
        use2        = 1'b1;
        imm_c       = imm6_sx;
        mem_write_c = 1'b1;
      end
      OP_BEQ: begin
        raddr1   = rd_f;
        raddr2   = rs_f;
        use1     = 1'b1;
        use2     = 1'b1;
        imm_c    = imm6_sx;
        branch_c = 1'b1;
      end
      OP_J: begin
        imm_c    = imm12_sx;
        branch_c = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.rf_raddr1 = raddr1;
  assign bus.rf_raddr2 = raddr2;

  logic [1:0][AW-1:0] src_addr;
  logic [1:0][DW-1:0] src_rdata;
  logic [1:0][DW-1:0] src_val;
  logic [1:0]         src_used;
  logic [1:0]         src_hit;
  logic               load_in_ex;

  assign src_addr  = {raddr2, raddr1};
  assign src_rdata = {bus.rf_rdata2, bus.rf_rdata1};
  assign src_used  = {use2, use1};
  assign load_in_ex = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      // The writeback path covers the edge where the register file has not
      // yet exposed the value it is committing.
      assign src_val[gi] =
        (!src_used[gi] || src_addr[gi] == '0)                      ? '0 :
        (bus.mem_fwd_valid && bus.mem_fwd_addr == src_addr[gi])    ? bus.mem_fwd_data :
        (bus.wb_wea && bus.wb_waddr == src_addr[gi])               ? bus.wb_wdata :
                                                                     src_rdata[gi];
      assign src_hit[gi] = load_in_ex && src_used[gi] && (src_addr[gi] == ex_q.rd);
    end
  endgenerate

  logic load_use;
  logic stall_c;
  logic issue_c;

  assign load_use = bus.if_valid && (|src_hit);

  always_comb begin
    state_d = state_q;
    stall_c = 1'b0;
    issue_c = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.flush) begin
          stall_c = 1'b0;
        end else if (load_use) begin
          stall_c = 1'b1;
        end else if (bus.if_valid) begin
          issue_c = 1'b1;
          if (op_f == OP_HALT) state_d = ST_HALT_PEND;
        end
      end
      ST_HALT_PEND: begin
        stall_c = !bus.flush;
        state_d = bus.flush ? ST_RUN : ST_HALTED;
      end
      ST_HALTED: begin
        stall_c = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
    if (rst) stall_c = 1'b0;
  end

  always_comb begin
    ex_d = '0;
    if (issue_c) begin
      ex_d.valid     = 1'b1;
      ex_d.op        = op_f;
      ex_d.rd        = rd_f;
      ex_d.a         = src_val[0];
      ex_d.b         = src_val[1];
      ex_d.imm       = imm_c;
      ex_d.pc        = bus.if_pc;
      ex_d.reg_write = reg_write_c;
      ex_d.mem_read  = mem_read_c;
      ex_d.mem_write = mem_write_c;
      ex_d.branch    = branch_c;
    end
  end

  always_ff @(posedge clk_n) begin
    if (rst) begin
      state_q <= ST_RUN;
      ex_q    <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
    end
  end

  assign bus.if_stall     = stall_c;
  assign bus.halted       = (state_q == ST_HALTED);
  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_op        = ex_q.op;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_a         = ex_q.a;
  assign bus.ex_b         = ex_q.b;
  assign bus.ex_imm       = ex_q.imm;
  assign bus.ex_pc        = ex_q.pc;
  assign bus.ex_reg_write = ex_q.reg_write;
  assign bus.ex_mem_read  = ex_q.mem_read;
  assign bus.ex_mem_write = ex_q.mem_write;
  assign bus.ex_branch    = ex_q.branch;
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: the driver queues hand-computed expectations,
// a negedge monitor checks if_stall/raddr in-cycle and the ID/EX word after the edge.
module tb_id_stage;
  logic clk_n = 1'b0;
  logic rst   = 1'b1;
  always #5 clk_n = ~clk_n;

  id_stage_if #(.DW(16), .AW(3)) bus ();

  id_stage #(.DW(16), .AW(3)) dut (
    .clk_n (clk_n),
    .rst   (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    logic [15:0] pc;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
  } word_t;

  typedef struct {
    int          tag;
    logic        stall;
    logic [2:0]  ra1;
    logic [2:0]  ra2;
    word_t       w;
    logic        halted;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  word_t bub;

  logic        s_rst, s_valid, s_flush, s_mfv, s_wbe;
  logic [15:0] s_instr, s_pc, s_rd1, s_rd2, s_mfd, s_wbd;
  logic [2:0]  s_mfa, s_wba;

  function automatic word_t mk(input logic [3:0] op, input logic [2:0] rd,
                               input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] imm, input logic [15:0] pc,
                               input logic rw, input logic mr, input logic mw, input logic br);
    word_t w;
    w.valid = 1'b1; w.op = op; w.rd = rd; w.a = a; w.b = b; w.imm = imm; w.pc = pc;
    w.rw = rw; w.mr = mr; w.mw = mw; w.br = br;
    return w;
  endfunction

  task automatic chk(input string name, input int tag, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s txn %0d: got %0h required %0h", name, tag, act, req);
    end
  endtask

  task automatic idle();
    s_rst = 0; s_valid = 0; s_flush = 0; s_instr = 16'h0000; s_pc = 16'h0000;
    s_rd1 = 16'h0000; s_rd2 = 16'h0000;
    s_mfv = 0; s_mfa = 3'd0; s_mfd = 16'h0000;
    s_wbe = 0; s_wba = 3'd0; s_wbd = 16'h0000;
  endtask

  task automatic issue(input int tag, input logic stall, input logic [2:0] ra1, input logic [2:0] ra2,
                       input word_t w, input logic halted);
    exp_t e;
    @(posedge clk_n);
    #1;
    rst               = s_rst;
    bus.if_valid      = s_valid;
    bus.if_instr      = s_instr;
    bus.if_pc         = s_pc;
    bus.flush         = s_flush;
    bus.rf_rdata1     = s_rd1;
    bus.rf_rdata2     = s_rd2;
    bus.mem_fwd_valid = s_mfv;
    bus.mem_fwd_addr  = s_mfa;
    bus.mem_fwd_data  = s_mfd;
    bus.wb_wea        = s_wbe;
    bus.wb_waddr      = s_wba;
    bus.wb_wdata      = s_wbd;
    e.tag = tag; e.stall = stall; e.ra1 = ra1; e.ra2 = ra2; e.w = w; e.halted = halted;
    exp_q.push_back(e);
  endtask

  // Monitor: finish the word check of the previous transaction, then take the next one.
  initial begin
    exp_t  pend;
    exp_t  cur;
    word_t act;
    bit    have = 0;
    forever begin
      @(negedge clk_n);
      if (have) begin
        act.valid = bus.ex_valid; act.op = bus.ex_op; act.rd = bus.ex_rd;
        act.a = bus.ex_a; act.b = bus.ex_b; act.imm = bus.ex_imm; act.pc = bus.ex_pc;
        act.rw = bus.ex_reg_write; act.mr = bus.ex_mem_read;
        act.mw = bus.ex_mem_write; act.br = bus.ex_branch;
        chk("ex_word", pend.tag, 128'(act), 128'(pend.w));
        chk("halted", pend.tag, 128'(bus.halted), 128'(pend.halted));
        $display("txn %0d: valid=%0b op=%0h rd=%0d a=%04h b=%04h imm=%04h pc=%04h ctl=%b%b%b%b halted=%0b",
                 pend.tag, act.valid, act.op, act.rd, act.a, act.b, act.imm, act.pc,
                 act.rw, act.mr, act.mw, act.br, bus.halted);
        have = 0;
      end
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        chk("if_stall", cur.tag, 128'(bus.if_stall), 128'(cur.stall));
        chk("rf_raddr1", cur.tag, 128'(bus.rf_raddr1), 128'(cur.ra1));
        chk("rf_raddr2", cur.tag, 128'(bus.rf_raddr2), 128'(cur.ra2));
        pend = cur;
        have = 1;
      end
    end
  end

  initial begin
    bub = '0;
    bus.if_valid = 0; bus.if_instr = 16'h0; bus.if_pc = 16'h0; bus.flush = 0;
    bus.rf_rdata1 = 16'h0; bus.rf_rdata2 = 16'h0;
    bus.mem_fwd_valid = 0; bus.mem_fwd_addr = 3'd0; bus.mem_fwd_data = 16'h0;
    bus.wb_wea = 0; bus.wb_waddr = 3'd0; bus.wb_wdata = 16'h0;

    // reset with a valid instruction present
    idle(); s_rst = 1; s_valid = 1; s_instr = 16'h0298; s_rd1 = 16'd5; s_rd2 = 16'd7;
    issue(0, 0, 3'd2, 3'd3, bub, 0);
    issue(1, 0, 3'd2, 3'd3, bub, 0);

    // ADD r1,r2,r3
    idle(); s_valid = 1; s_instr = 16'h0298; s_pc = 16'h0010; s_rd1 = 16'd5; s_rd2 = 16'd7;
    issue(2, 0, 3'd2, 3'd3, mk(4'h0, 3'd1, 16'd5, 16'd7, 16'h0, 16'h0010, 1, 0, 0, 0), 0);

    // ADD r2,r1,r1: mem_fwd beats wb beats rf
    s_instr = 16'h0448; s_pc = 16'h0012; s_rd1 = 16'h0011; s_rd2 = 16'h0011;
    s_mfv = 1; s_mfa = 3'd1; s_mfd = 16'h00AA; s_wbe = 1; s_wba = 3'd1; s_wbd = 16'h0055;
    issue(3, 0, 3'd1, 3'd1, mk(4'h0, 3'd2, 16'h00AA, 16'h00AA, 16'h0, 16'h0012, 1, 0, 0, 0), 0);
    s_mfv = 0; s_pc = 16'h0014;
    issue(4, 0, 3'd1, 3'd1, mk(4'h0, 3'd2, 16'h0055, 16'h0055, 16'h0, 16'h0014, 1, 0, 0, 0), 0);

    // ADD r2,r0,r0 with every path driving r0 = 0xFFFF
    s_instr = 16'h0400; s_pc = 16'h0016; s_rd1 = 16'hFFFF; s_rd2 = 16'hFFFF;
    s_mfv = 1; s_mfa = 3'd0; s_mfd = 16'hFFFF; s_wbe = 1; s_wba = 3'd0; s_wbd = 16'hFFFF;
    issue(5, 0, 3'd0, 3'd0, mk(4'h0, 3'd2, 16'h0, 16'h0, 16'h0, 16'h0016, 1, 0, 0, 0), 0);

    // LW r3,2(r1) then ADD r4,r3,r2: one bubble, then mem_fwd value
    idle(); s_valid = 1; s_instr = 16'h5642; s_pc = 16'h0018; s_rd1 = 16'h0100;
    issue(6, 0, 3'd1, 3'd0, mk(4'h5, 3'd3, 16'h0100, 16'h0, 16'h0002, 16'h0018, 1, 1, 0, 0), 0);
    s_instr = 16'h08D0; s_pc = 16'h001A; s_rd1 = 16'h1111; s_rd2 = 16'h0022;
    issue(7, 1, 3'd3, 3'd2, bub, 0);
    s_mfv = 1; s_mfa = 3'd3; s_mfd = 16'h0BEE;
    issue(8, 0, 3'd3, 3'd2, mk(4'h0, 3'd4, 16'h0BEE, 16'h0022, 16'h0, 16'h001A, 1, 0, 0, 0), 0);

    // LW r0 followed by a use of r0: no stall
    idle(); s_valid = 1; s_instr = 16'h5041; s_pc = 16'h001C; s_rd1 = 16'h0100;
    issue(9, 0, 3'd1, 3'd0, mk(4'h5, 3'd0, 16'h0100, 16'h0, 16'h0001, 16'h001C, 1, 1, 0, 0), 0);
    s_instr = 16'h0A00; s_pc = 16'h001E; s_rd1 = 16'h0000;
    issue(10, 0, 3'd0, 3'd0, mk(4'h0, 3'd5, 16'h0, 16'h0, 16'h0, 16'h001E, 1, 0, 0, 0), 0);

    // flush during a load-use stall, then an invalid slot
    s_instr = 16'h5642; s_pc = 16'h0020; s_rd1 = 16'h0100;
    issue(11, 0, 3'd1, 3'd0, mk(4'h5, 3'd3, 16'h0100, 16'h0, 16'h0002, 16'h0020, 1, 1, 0, 0), 0);
    s_instr = 16'h08D0; s_pc = 16'h0022; s_flush = 1; s_rd1 = 16'h1111; s_rd2 = 16'h0022;
    issue(12, 0, 3'd3, 3'd2, bub, 0);
    idle(); s_instr = 16'h0298; s_rd1 = 16'd5; s_rd2 = 16'd7;
    issue(13, 0, 3'd2, 3'd3, bub, 0);

    // immediates, branch, store
    idle(); s_valid = 1; s_instr = 16'h423F; s_pc = 16'h0024; s_rd1 = 16'h1234;
    issue(14, 0, 3'd0, 3'd0, mk(4'h4, 3'd1, 16'h0, 16'h0, 16'hFFFF, 16'h0024, 1, 0, 0, 0), 0);
    s_instr = 16'h8800; s_pc = 16'h0026;
    issue(15, 0, 3'd0, 3'd0, mk(4'h8, 3'd4, 16'h0, 16'h0, 16'hF800, 16'h0026, 0, 0, 0, 1), 0);
    s_instr = 16'h7283; s_pc = 16'h0028; s_rd1 = 16'h000A; s_rd2 = 16'h000B;
    issue(16, 0, 3'd1, 3'd2, mk(4'h7, 3'd1, 16'h000A, 16'h000B, 16'h0003, 16'h0028, 0, 0, 0, 1), 0);
    s_instr = 16'h6684; s_pc = 16'h002A; s_rd1 = 16'h0033; s_rd2 = 16'h0044;
    issue(17, 0, 3'd3, 3'd2, mk(4'h6, 3'd3, 16'h0033, 16'h0044, 16'h0004, 16'h002A, 0, 0, 1, 0), 0);

    // HALT -> HALT_PEND -> HALTED, then reset out of HALTED
    s_instr = 16'hF000; s_pc = 16'h002C; s_rd1 = 16'h0; s_rd2 = 16'h0;
    issue(18, 0, 3'd0, 3'd0, mk(4'hF, 3'd0, 16'h0, 16'h0, 16'h0, 16'h002C, 0, 0, 0, 0), 0);
    s_instr = 16'h0298; s_pc = 16'h002E; s_rd1 = 16'd5; s_rd2 = 16'd7;
    issue(19, 1, 3'd2, 3'd3, bub, 1);
    issue(20, 1, 3'd2, 3'd3, bub, 1);
    s_rst = 1;
    issue(21, 0, 3'd2, 3'd3, bub, 0);
    s_rst = 0;

    // HALT with flush in the HALT_PEND cycle returns to RUN
    s_instr = 16'hF000; s_pc = 16'h0030; s_rd1 = 16'h0; s_rd2 = 16'h0;
    issue(22, 0, 3'd0, 3'd0, mk(4'hF, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0030, 0, 0, 0, 0), 0);
    s_instr = 16'h0298; s_pc = 16'h0032; s_flush = 1; s_rd1 = 16'd5; s_rd2 = 16'd7;
    issue(23, 0, 3'd2, 3'd3, bub, 0);
    s_flush = 0; s_pc = 16'h0040;
    issue(24, 0, 3'd2, 3'd3, mk(4'h0, 3'd1, 16'd5, 16'd7, 16'h0, 16'h0040, 1, 0, 0, 0), 0);

    idle();
    @(posedge clk_n); #1;
    bus.if_valid = 0; bus.flush = 0;
    repeat (3) @(posedge clk_n);
    chk("scoreboard_drained", -1, 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
